bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It supersedes fixed lookup conversion for display paths such as timer minutes/seconds feeding the 7-segment drivers. Any input width and digit count are supported. Valid/ready handshakes on input and output, plus overflow saturation and leading-zero blank flags.

Parameters:
BIN_WIDTH, 8, width of binary input; legal range >= 1.
DIGITS, 3, number of BCD digits presented at the output; legal range >= 1.

Ports:
clk  input  1  system clock, rising edge.
resetN  input  1  asynchronous active-low reset.
inValid  input  1  binIn is valid this cycle.
inReady  output  1  block can accept a new value.
binIn  input  BIN_WIDTH  unsigned binary value.
outValid  output  1  bcdOut, overflow and blank are valid.
outReady  input  1  consumer accepts the result.
bcdOut  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].
overflow  output  1  input exceeded 10^DIGITS-1; bcdOut saturated.
blank  output  DIGITS  per-digit leading-zero flag; bit 0 always 0.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (resetN), and it takes effect immediately regardless of clk.
- Reset values:
  - state = IDLE.
  - inReady = 1; outValid = 0.
  - bcdOut = 0; overflow = 0; blank = 0.
  - Internal shift register and counter = 0.
- Internal digit count: INT_DIGITS = max(DIGITS, (BIN_WIDTH+2)/3).
  - This always holds 2^BIN_WIDTH-1.
  - Scratch register width is 4*INT_DIGITS + BIN_WIDTH.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - inReady = 1.
  - On inValid&&inReady: load the binary field with binIn, clear BCD field, set bit counter = BIN_WIDTH, go to SHIFT.
- SHIFT:
  - inReady = 0.
  - Each edge: every internal digit >= 5 gets +3 (combinational, all digits in parallel), then the whole scratch register shifts left 1. Counter decrements.
  - On the edge where the counter reaches 0, go to DONE and register the outputs.
- Output registration on entry to DONE:
  - If any internal digit at index >= DIGITS is nonzero: overflow = 1 and bcdOut = all 4'h9.
  - Otherwise overflow = 0 and bcdOut = low DIGITS digits.
  - blank[i] = 1 iff digits DIGITS-1 down to i are all zero, for i >= 1. blank[0] = 0.
  - On overflow, blank = 0.
- Latency: outValid rises exactly BIN_WIDTH clock edges after the accepting edge.
- DONE:
  - outValid = 1; inReady = 0.
  - bcdOut, overflow and blank are held stable while outReady = 0 (no limit).
  - On outValid&&outReady: go to IDLE, outValid = 0 next cycle. Outputs keep their last value, but are only meaningful while outValid = 1.
- No same-cycle accept in DONE: a new input is accepted no earlier than the cycle after the output handshake.
- inValid outside IDLE is ignored. binIn is sampled only at the accepting edge, so later changes to it have no effect.
- Simultaneous outReady and inValid in DONE: the output handshake completes; the input is not accepted until IDLE.
- Reset mid-operation (SHIFT or DONE): immediate return to reset values. The in-flight conversion is discarded and no outValid is produced.
- binIn = 0: result 0, blank = all ones except bit 0, same latency.
- BIN_WIDTH = 1: one SHIFT cycle.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - enum conv_state_t {IDLE, SHIFT, DONE}.
  - Constant function int_digits(width, digits) for INT_DIGITS.
  - Constant BCD_NINE = 4'h9.
- Sub-module bcd_digit_adj: combinational, one digit in, one digit out (d >= 5 ? d+3 : d). Instantiated INT_DIGITS times in a generate loop.
- FSM, counter and output registers live in the top module.

Test Plan:
1. Reset:
   - Stimulus: assert resetN = 0 for 3 cycles, then release.
   - Required: inReady = 1, outValid = 0, bcdOut = 12'h000, overflow = 0, blank = 3'b000.
2. Default params, binIn = 8'd255:
   - Required: outValid exactly 8 edges after accept; bcdOut = 12'h255; overflow = 0; blank = 3'b000.
   - Also: binIn = 8'd7 -> bcdOut = 12'h007, blank = 3'b110.
3. DIGITS = 2, BIN_WIDTH = 8, binIn = 8'd200:
   - Required: overflow = 1, bcdOut = 8'h99, blank = 2'b00.
   - Also: binIn = 8'd99 -> overflow = 0, bcdOut = 8'h99.
4. Back-pressure:
   - Stimulus: outReady = 0 for 5 cycles after outValid while pulsing inValid with binIn = 8'd42.
   - Required: bcdOut stays 12'h(previous result), inReady = 0, no accept.
   - Then: outReady = 1 -> IDLE; inReady = 1 next cycle; 42 converts to 12'h042.
5. Reset during SHIFT:
   - Stimulus: deassert resetN on the 4th SHIFT cycle of a conversion of 8'd128.
   - Required: immediate IDLE, outValid never rises.
   - Then: a fresh conversion of 8'd31 yields 12'h031, blank = 3'b100.
6. Exhaustive sweep, BIN_WIDTH = 6, DIGITS = 2:
   - Stimulus: inputs 0..63 back-to-back with outReady = 1.
   - Required: each result matches the golden decimal split (e.g. 31 -> 8'h31, 63 -> 8'h63); blank[1] = 1 only for 0..9; overflow never set.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    localparam bcd_digit_t BCD_NINE = 4'h9;

    // Enough internal digits to hold 2^width-1, never fewer than the presented digits.
    function automatic int unsigned int_digits(input int unsigned width,
                                               input int unsigned digits);
        int unsigned need;
        need = (width + 2) / 3;
        return (digits > need) ? digits : need;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    // Pre-shift correction so the doubled digit carries correctly into the next one.
    always_comb begin
        digit_o = (digit_i >= 4'd5) ? bcd_digit_t'(digit_i + 4'd3) : digit_i;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes, overflow saturation and leading-zero blank flags.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 8,
    parameter int unsigned DIGITS    = 3
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [BIN_WIDTH-1:0]  binIn,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [4*DIGITS-1:0]   bcdOut,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int unsigned IntDigits = int_digits(BIN_WIDTH, DIGITS);
    localparam int unsigned BcdW      = 4 * IntDigits;
    localparam int unsigned ScrW      = BcdW + BIN_WIDTH;
    localparam int unsigned CntW      = $clog2(BIN_WIDTH + 1);

    conv_state_t           state_q, state_d;
    logic [ScrW-1:0]       scratch_q, scratch_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic [DIGITS-1:0]     blank_q, blank_d;

    // Scratch layout: BCD digits above, remaining binary bits below.
    logic [ScrW-1:0]       adj;
    logic [ScrW-1:0]       shifted;
    logic [4*DIGITS-1:0]   res_bcd;
    logic                  res_ovf;
    logic [DIGITS-1:0]     res_blank;

    assign adj[BIN_WIDTH-1:0] = scratch_q[BIN_WIDTH-1:0];

    for (genvar g = 0; g < int'(IntDigits); g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[BIN_WIDTH+4*g +: 4]),
            .digit_o (adj[BIN_WIDTH+4*g +: 4])
        );
    end

    assign shifted = adj << 1;

    // Final result derived from the value the last shift will produce.
    always_comb begin
        logic all_zero;
        res_ovf   = 1'b0;
        res_blank = '0;
        all_zero  = 1'b1;
        for (int unsigned i = DIGITS; i < IntDigits; i++) begin
            if (shifted[BIN_WIDTH+4*i +: 4] != 4'd0) res_ovf = 1'b1;
        end
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (shifted[BIN_WIDTH+4*i +: 4] != 4'd0) all_zero = 1'b0;
            res_blank[i] = all_zero;
        end
        if (res_ovf) begin
            res_bcd   = {DIGITS{BCD_NINE}};
            res_blank = '0;
        end else begin
            res_bcd   = shifted[BIN_WIDTH +: 4*DIGITS];
        end
    end

    // Next-state logic: load in IDLE, shift BIN_WIDTH times, hold result in DONE.
    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        blank_d   = blank_q;
        unique case (state_q)
            IDLE: begin
                if (inValid) begin
                    scratch_d = {{BcdW{1'b0}}, binIn};
                    cnt_d     = CntW'(BIN_WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = DONE;
                    bcd_d   = res_bcd;
                    ovf_d   = res_ovf;
                    blank_d = res_blank;
                end
            end
            DONE: begin
                if (outReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and result registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            blank_q   <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            blank_q   <= blank_d;
        end
    end

    assign inReady  = (state_q == IDLE);
    assign outValid = (state_q == DONE);
    assign bcdOut   = bcd_q;
    assign overflow = ovf_q;
    assign blank    = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three instances (8b/3 digits, 8b/2 digits in lockstep,
// 6b/2 digits swept), all results compared with a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        resetN;
    logic        inValid, outReady;
    logic [7:0]  binIn;

    logic        inReady_a, outValid_a, ovf_a;
    logic [11:0] bcd_a;
    logic [2:0]  blank_a;

    logic        inReady_b, outValid_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [1:0]  blank_b;

    logic        inValid_c, outReady_c, inReady_c, outValid_c, ovf_c;
    logic [5:0]  binIn_c;
    logic [7:0]  bcd_c;
    logic [1:0]  blank_c;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) dut_a (
        .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady_a), .binIn(binIn),
        .outValid(outValid_a), .outReady(outReady), .bcdOut(bcd_a), .overflow(ovf_a),
        .blank(blank_a)
    );

    bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady_b), .binIn(binIn),
        .outValid(outValid_b), .outReady(outReady), .bcdOut(bcd_b), .overflow(ovf_b),
        .blank(blank_b)
    );

    bin_to_bcd_seq #(.BIN_WIDTH(6), .DIGITS(2)) dut_c (
        .clk(clk), .resetN(resetN), .inValid(inValid_c), .inReady(inReady_c),
        .binIn(binIn_c), .outValid(outValid_c), .outReady(outReady_c), .bcdOut(bcd_c),
        .overflow(ovf_c), .blank(blank_c)
    );

    // Reference: decimal digits by repeated division, saturating beyond nd digits.
    function automatic logic [15:0] model_bcd(input int unsigned v, input int unsigned nd);
        logic [15:0] r;
        int unsigned lim, x;
        r = '0;
        lim = 1;
        for (int k = 0; k < int'(nd); k++) lim = lim * 10;
        x = v;
        for (int k = 0; k < int'(nd); k++) begin
            r[4*k +: 4] = (v >= lim) ? 4'd9 : 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] model_ovf(input int unsigned v, input int unsigned nd);
        int unsigned lim;
        lim = 1;
        for (int k = 0; k < int'(nd); k++) lim = lim * 10;
        return (v >= lim) ? 16'd1 : 16'd0;
    endfunction

    function automatic logic [15:0] model_blank(input int unsigned v, input int unsigned nd);
        logic [15:0] b;
        int unsigned nsig, x;
        b = '0;
        if (model_ovf(v, nd) != 16'd0) return b;
        nsig = 1;
        x = v / 10;
        while (x != 0) begin
            nsig++;
            x = x / 10;
        end
        for (int i = 1; i < int'(nd); i++) b[i] = (i >= int'(nsig));
        return b;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion on the 8-bit pair; hold>0 keeps outReady low for hold cycles in DONE
    // while offering a competing input that must be ignored.
    task automatic run_ab(input logic [7:0] v, input int hold);
        int lat;
        @(negedge clk);
        check("a_in_ready_idle", 16'(inReady_a), 16'd1);
        binIn    = v;
        inValid  = 1'b1;
        outReady = (hold == 0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        binIn   = 8'($urandom);
        lat = 0;
        while (!outValid_a && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 16'(lat), 16'd8);
        check("a_bcd", 16'(bcd_a), model_bcd(v, 3));
        check("a_ovf", 16'(ovf_a), model_ovf(v, 3));
        check("a_blank", 16'(blank_a), model_blank(v, 3));
        check("b_valid", 16'(outValid_b), 16'd1);
        check("b_bcd", 16'(bcd_b), model_bcd(v, 2));
        check("b_ovf", 16'(ovf_b), model_ovf(v, 2));
        check("b_blank", 16'(blank_b), model_blank(v, 2));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            inValid = 1'b1;
            binIn   = 8'd42;
            @(posedge clk);
            #1;
            check("hold_bcd", 16'(bcd_a), model_bcd(v, 3));
            check("hold_in_ready", 16'(inReady_a), 16'd0);
            check("hold_valid", 16'(outValid_a), 16'd1);
        end
        if (hold > 0) begin
            @(negedge clk);
            inValid  = 1'b0;
            outReady = 1'b1;
        end
        @(posedge clk);
        #1;
        check("a_valid_drop", 16'(outValid_a), 16'd0);
        check("a_in_ready_back", 16'(inReady_a), 16'd1);
    endtask

    task automatic run_c(input logic [5:0] v);
        int lat;
        @(negedge clk);
        check("c_in_ready", 16'(inReady_c), 16'd1);
        binIn_c    = v;
        inValid_c  = 1'b1;
        outReady_c = 1'b1;
        @(posedge clk);
        #1;
        inValid_c = 1'b0;
        lat = 0;
        while (!outValid_c && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("c_latency", 16'(lat), 16'd6);
        check("c_bcd", 16'(bcd_c), model_bcd(v, 2));
        check("c_ovf", 16'(ovf_c), 16'd0);
        check("c_blank", 16'(blank_c), model_blank(v, 2));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        resetN     = 1'b0;
        inValid    = 1'b0;
        outReady   = 1'b1;
        binIn      = '0;
        inValid_c  = 1'b0;
        outReady_c = 1'b1;
        binIn_c    = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        check("rst_in_ready", 16'(inReady_a), 16'd1);
        check("rst_out_valid", 16'(outValid_a), 16'd0);
        check("rst_bcd", 16'(bcd_a), 16'h000);
        check("rst_ovf", 16'(ovf_a), 16'd0);
        check("rst_blank", 16'(blank_a), 16'd0);
        check("rst_c_blank", 16'(blank_c), 16'd0);

        // Directed values, including DIGITS=2 overflow on the lockstep instance
        run_ab(8'd255, 0);
        run_ab(8'd7, 0);
        run_ab(8'd0, 0);
        run_ab(8'd200, 0);
        run_ab(8'd99, 0);
        run_ab(8'd100, 0);

        // Back-pressure with ignored input, then 42 converts normally
        run_ab(8'd137, 5);
        run_ab(8'd42, 0);

        // Reset on the 4th SHIFT cycle of 128
        @(negedge clk);
        binIn   = 8'd128;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check("midrst_in_ready", 16'(inReady_a), 16'd1);
        check("midrst_valid", 16'(outValid_a), 16'd0);
        check("midrst_bcd", 16'(bcd_a), 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (outValid_a) seen = 1'b1;
        end
        check("midrst_no_valid", 16'(seen), 16'd0);
        run_ab(8'd31, 0);

        // Random values with random back-pressure
        for (int i = 0; i < 30; i++) begin
            run_ab(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        end

        // Exhaustive 6-bit sweep
        for (int v = 0; v < 64; v++) run_c(6'(v));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
